// File: rtl/fpmul_pkg.sv
// fpmul_pkg: FP32 field constants, exception flag type and flag decode shared by the multiplier adapter
package fpmul_pkg;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_MSB = 22;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_flags_t;

    function automatic fp_flags_t fp_decode(input logic [31:0] v);
        logic emax;
        logic mnz;
        emax = &v[EXP_MSB:EXP_LSB];
        mnz  = |v[MAN_MSB:0];
        return '{nan: emax & mnz, inf: emax & ~mnz, zero: ~|v[EXP_MSB:0]};
    endfunction
endpackage

// File: rtl/fpmul_res_fifo.sv
// fpmul_res_fifo: synchronous result FIFO with a registered head entry and occupancy count
// Ports: CLK, RESET (async active-low), push/din write side, pop read side,
//        occ occupancy (one bit wider than the pointers), head oldest entry (registered).
module fpmul_res_fifo
    import fpmul_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 36
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] occ,
    output logic [W-1:0]           head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rnext;

    assign rnext = rptr + 1'b1;

    always_ff @(posedge CLK)
        if (push) mem[wptr] <= din;

    // head mirrors mem[rptr]: it takes din when the write lands in the head slot,
    // otherwise the next stored entry on a pop
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            head <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rnext;
            occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (push && (occ == '0 || (pop && occ == ONE))) head <= din;
            else if (pop && occ > ONE) head <= mem[rnext];
        end
endmodule

// File: rtl/fpmul_stream_adapter.sv
// fpmul_stream_adapter: valid/ready wrapper around the fixed-latency FP32 multiplier with credit-checked result FIFO
// Ports: CLK, RESET (async active-low); IVAL/IRDY/IA/IB/IID operand input; MACT/MTAG/MA/MB multiplier issue;
//        MRDY/MTAGI/MR multiplier result; OVAL/ORDY/ORES/OID result output; OCNT occupancy; ERR sticky error.
// Define FPMUL_EXC_FLAGS_EN to add OFLG = {nan, inf, zero} stored with each result.
module fpmul_stream_adapter
    import fpmul_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LAT   = 3,
    parameter int IDW   = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IVAL,
    output logic                   IRDY,
    input  logic [31:0]            IA,
    input  logic [31:0]            IB,
    input  logic [IDW-1:0]         IID,
    output logic                   MACT,
    output logic                   MTAG,
    output logic [31:0]            MA,
    output logic [31:0]            MB,
    input  logic                   MRDY,
    input  logic                   MTAGI,
    input  logic [31:0]            MR,
    output logic                   OVAL,
    input  logic                   ORDY,
    output logic [31:0]            ORES,
    output logic [IDW-1:0]         OID,
    output logic [$clog2(DEPTH):0] OCNT,
    output logic                   ERR
`ifdef FPMUL_EXC_FLAGS_EN
    ,
    output logic [2:0]             OFLG
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(LAT + 2);
    localparam logic [CW:0]   LIM = (CW+1)'(DEPTH);
    localparam logic [BW-1:0] BLK = BW'(LAT + 1);

    typedef struct packed {
        logic [31:0]    res;
        logic [IDW-1:0] id;
`ifdef FPMUL_EXC_FLAGS_EN
        fp_flags_t      flg;
`endif
    } entry_t;

    entry_t         din, head;
    logic [CW-1:0]  infl;
    logic [CW:0]    used;
    logic [BW-1:0]  blank;
    logic [LAT:0]   pv;
    logic [IDW-1:0] pid [LAT+1];
    logic [IDW-1:0] mid;
    logic           acc, rdy, mat, pop, full, push, err_set;

    // credits: every accepted op owns a FIFO slot until it is captured or declared lost
    assign used    = {1'b0, OCNT} + {1'b0, infl};
    assign IRDY    = (blank == '0) && (used < LIM);
    assign acc     = IVAL & IRDY;
    assign rdy     = MRDY & (blank == '0);
    assign mat     = pv[LAT];
    assign OVAL    = OCNT != '0;
    assign pop     = OVAL & ORDY;
    assign full    = OCNT == LIM[CW-1:0];
    assign push    = rdy & mat & ~(full & ~pop);
    assign err_set = (rdy & (~mat | ~MTAGI | (full & ~pop))) | (mat & ~rdy);
    assign MTAG    = MACT;

    assign din.res = MR;
    assign din.id  = pid[LAT];
    assign ORES    = head.res;
    assign OID     = head.id;
`ifdef FPMUL_EXC_FLAGS_EN
    assign din.flg = fp_decode(MR);
    assign OFLG    = head.flg;
`endif

    // pv/pid follow MACT/mid one cycle behind, so pv[LAT] lines up with the MRDY cycle
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            MACT  <= 1'b0;
            MA    <= '0;
            MB    <= '0;
            mid   <= '0;
            pv    <= '0;
            for (int i = 0; i <= LAT; i++) pid[i] <= '0;
            infl  <= '0;
            blank <= BLK;
            ERR   <= 1'b0;
        end else begin
            MACT <= acc;
            if (acc) begin
                MA  <= IA;
                MB  <= IB;
                mid <= IID;
            end
            pv     <= {pv[LAT-1:0], MACT};
            pid[0] <= mid;
            for (int i = 1; i <= LAT; i++) pid[i] <= pid[i-1];
            infl <= infl + {{(CW-1){1'b0}}, acc} - {{(CW-1){1'b0}}, mat};
            if (blank != '0) blank <= blank - 1'b1;
            ERR <= ERR | err_set;
        end

    fpmul_res_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
        .CLK  (CLK),
        .RESET(RESET),
        .push (push),
        .din  (din),
        .pop  (pop),
        .occ  (OCNT),
        .head (head)
    );
endmodule
